nibble_serial_add_seq: RTL and testbench
========================================

// Module: nibble_serial_add_seq
// PURPOSE
//  Feeds an external combinational 4-bit adder slice one nibble per clock, LS nibble first.
//  Ripples that slice's carry through a register, so one slice adds WIDTH-bit operands.
//  Collects the slice sums into a WIDTH-bit result and returns it with carry-out and signed overflow.
//  Sits directly upstream of the 4-bit adder; valid/ready handshake to the operand source and the result sink.
// PARAMETERS
//  WIDTH   16   operand/result width; multiple of 4, >= 8
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      operand request valid
//  in_ready   out  1      block can accept operands
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in to LS nibble
//  add_a      out  4      nibble A to adder slice
//  add_b      out  4      nibble B to adder slice
//  add_cin    out  1      carry to adder slice
//  add_sum    in   4      slice sum, combinational from add_a/add_b/add_cin
//  add_cout   in   1      slice carry-out, combinational
//  out_valid  out  1      result valid
//  out_ready  in   1      sink accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry-out of MS nibble
//  out_ovf    out  1      signed overflow
// BEHAVIOUR
//  Reset state: state=IDLE; in_ready=1; out_valid=0; out_sum=0; out_cout=0; out_ovf=0; add_*=0.
//  rst_n low mid-operation aborts: operation discarded, nothing emitted.
//  The FSM has three states: IDLE, RUN, DONE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid: latch in_a, in_b; carry reg <= in_cin; nibble counter idx <= 0; go to RUN.
//  RUN:
//   - in_ready=0.
//   - Drive add_a/add_b with nibble idx of the latched operands; add_cin = carry reg.
//   - Each clock: out_sum nibble idx <= add_sum; carry reg <= add_cout; idx++.
//   - When idx == WIDTH/4-1, capture that nibble and go to DONE.
//  Exactly WIDTH/4 cycles are spent in RUN.
//  DONE:
//   - out_valid=1; out_cout = carry reg.
//   - out_ovf = (A_msb == Beff_msb) && (out_sum_msb != A_msb).
//   - On out_ready go to IDLE; out_valid drops next cycle.
//   - out_sum, out_cout and out_ovf hold until the next result.
//  Latency: out_valid rises WIDTH/4+1 clocks after the accepting edge.
//  Throughput: one op per WIDTH/4+2 clocks with out_ready tied high.
//  No new accept while busy; in_valid outside IDLE is ignored and in_ready stays 0.
//  add_a/add_b/add_cin are 0 outside RUN, so the slice sees no activity while idle.
//  Carry wraps out only via out_cout; out_sum is modulo 2^WIDTH.
// CONFIGURATION
//  SUB_EN defined:
//   - Extra input port in_sub (1 bit), latched at accept.
//   - If in_sub=1: Beff = ~in_b and the initial carry = 1 (in_cin ignored), giving A-B.
//   - out_cout=1 means no borrow; out_ovf uses Beff.
//  SUB_EN undefined: no in_sub port; Beff = in_b; add only.
// STRUCTURE
//  Package add_seq_pkg:
//   - NIB_W=4.
//   - State enum {IDLE, RUN, DONE}.
//   - Function nibbles(WIDTH).
//  One sub-module, nibble_shreg:
//   - Operand shift register: loads A/Beff at accept and shifts right 4 per RUN cycle.
//   - Presents bits [3:0] as add_a/add_b, so no wide index mux is needed.
//  FSM, counter, carry reg and result assembly stay in the top.
// TESTING (WIDTH=16, bench models the adder slice behaviourally)
//  1. 0x1234+0x4321, cin=0 -> out_sum=0x5555, cout=0, ovf=0; out_valid exactly 5 clocks after accept.
//  2. 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, cout=1, ovf=0; full carry ripple across all 4 nibbles.
//  3. 0x00FF+0x0000, cin=1 -> 0x0100; 0x7FFF+0x0001 -> 0x8000, ovf=1.
//  4. out_ready low for 3 clocks in DONE -> out_valid and outputs held stable; in_valid ignored, in_ready=0.
//  5. rst_n low for 1 clock during RUN idx=2 -> next cycle IDLE, out_valid=0, out_sum=0; next op correct.
//  6. SUB_EN: 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package add_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nibbles(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_shreg.sv
// Operand shift register: loads A and effective B, then shifts one nibble per step
// so the low nibble is always the one the adder slice should see.
module nibble_shreg
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [NIB_W-1:0] nib_a_o,
  output logic [NIB_W-1:0] nib_b_o
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  always_ff @(posedge clk) begin
    if (load_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end else if (shift_i) begin
      a_q <= a_q >> NIB_W;
      b_q <= b_q >> NIB_W;
    end
  end

  assign nib_a_o = a_q[NIB_W-1:0];
  assign nib_b_o = b_q[NIB_W-1:0];

endmodule

// File: rtl/nibble_serial_add_seq.sv
// Drives an external 4-bit adder slice nibble by nibble to add WIDTH-bit operands.
// Optional subtract mode (in_sub port) is enabled by defining SUB_EN.
module nibble_serial_add_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SUB_EN
  input  logic             in_sub,
`endif
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIBS = nibbles(WIDTH);
  localparam int IDX_W = $clog2(NIBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             a_msb_q, b_msb_q;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             accept;
  logic             running;
  logic [NIB_W-1:0] nib_a, nib_b;

  // Subtraction is A + ~B + 1; the forced carry replaces in_cin.
`ifdef SUB_EN
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;
`else
  assign b_eff   = in_b;
  assign cin_eff = in_cin;
`endif

  assign accept  = (state_q == IDLE) && in_valid;
  assign running = (state_q == RUN);

  nibble_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk    (clk),
    .load_i (accept),
    .shift_i(running),
    .a_i    (in_a),
    .b_i    (b_eff),
    .nib_a_o(nib_a),
    .nib_b_o(nib_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slice inputs are forced to zero outside RUN to keep it quiet.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_a   = nib_a;
        add_b   = nib_b;
        add_cin = carry_q;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      idx_d   = '0;
      carry_d = cin_eff;
    end else if (running) begin
      sum_d[NIB_W*int'(idx_q) +: NIB_W] = add_sum;
      carry_d = add_cout;
      idx_d   = idx_q + IDX_W'(1);
      // Result flags are frozen at the MS nibble so they hold through IDLE.
      if (idx_q == LAST_IDX) begin
        cout_d = add_cout;
        ovf_d  = (a_msb_q == b_msb_q) && (add_sum[NIB_W-1] != a_msb_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_msb_q <= in_a[WIDTH-1];
      b_msb_q <= b_eff[WIDTH-1];
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq (WIDTH=16) with a behavioural 4-bit adder slice.
// Subtract tests are included when SUB_EN is defined.
module tb_nibble_serial_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        in_cin;
  logic        sub_sel;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic        out_cout, out_ovf;
`ifdef SUB_EN
  logic        in_sub;
  assign in_sub = sub_sel;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder slice.
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_add_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef SUB_EN
    .in_sub   (in_sub),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  // Reference: whole-word integer arithmetic, signed range test for overflow.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic sub, output logic [15:0] s, output logic co,
                                output logic ov);
    longint ur;
    int     sr;
    if (sub) begin
      ur = longint'(a) - longint'(b);
      sr = int'($signed(a)) - int'($signed(b));
      co = (a >= b);
    end else begin
      ur = longint'(a) + longint'(b) + longint'(cin);
      sr = int'($signed(a)) + int'($signed(b)) + int'(cin);
      co = (ur > 65535);
    end
    s  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  // Present one operand pair; lat counts edges from the accepting edge (=1) to out_valid.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; sub_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_sum !== 16'h0) begin n_fail++; $display("FAIL reset_out_sum got %h exp 0000", out_sum); end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got %b exp 0", out_cout); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
    n_checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin n_fail++; $display("FAIL reset_add got %h exp 000", {add_a, add_b, add_cin}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_directed();
    logic [15:0] ta [4] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h7FFF};
    logic [15:0] tb [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001};
    logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es [4] = '{16'h5555, 16'h0000, 16'h0100, 16'h8000};
    logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    sub_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], tc[i], lat);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL dir%0d_latency got %0d exp 5", i, lat); end
      n_checks++; if (out_sum !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum got %h exp %h", i, out_sum, es[i]); end
      n_checks++; if (out_cout !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout got %b exp %b", i, out_cout, ec[i]); end
      n_checks++; if (out_ovf !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ovf got %b exp %b", i, out_ovf, eo[i]); end
      n_checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin n_fail++; $display("FAIL dir%0d_add_idle got %h exp 000", i, {add_a, add_b, add_cin}); end
      consume();
    end
  endtask

  task automatic test_hold();
    logic [15:0] es;
    logic ec, eo;
    int lat;
    sub_sel = 1'b0;
    model(16'hA5C3, 16'h1111, 1'b0, 1'b0, es, ec, eo);
    do_op(16'hA5C3, 16'h1111, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold%0d_valid got %b exp 1", i, out_valid); end
      n_checks++; if ({out_sum, out_cout, out_ovf} !== {es, ec, eo}) begin n_fail++; $display("FAIL hold%0d_result got %h/%b/%b exp %h/%b/%b", i, out_sum, out_cout, out_ovf, es, ec, eo); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d_in_ready got %b exp 0", i, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got %b exp 1", in_ready); end
    n_checks++; if (out_sum !== es) begin n_fail++; $display("FAIL hold_release_sum got %h exp %h", out_sum, es); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] es;
    logic ec, eo;
    logic [15:0] a, b;
    int lat;
    sub_sel = 1'b0;
    @(negedge clk);
    in_a = 16'h9ABC; in_b = 16'h1357; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if ({add_a, add_b} !== 8'hA3) begin n_fail++; $display("FAIL mid_nibble2 got %h exp a3", {add_a, add_b}); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    n_checks++; if (out_sum !== 16'h0) begin n_fail++; $display("FAIL mid_rst_sum got %h exp 0000", out_sum); end
    repeat (6) begin @(posedge clk); #1; end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_emit got %b exp 0", out_valid); end
    a = 16'($urandom); b = 16'($urandom);
    model(a, b, 1'b1, 1'b0, es, ec, eo);
    do_op(a, b, 1'b1, lat);
    n_checks++; if ({out_sum, out_cout, out_ovf} !== {es, ec, eo}) begin n_fail++; $display("FAIL mid_next_op got %h/%b/%b exp %h/%b/%b", out_sum, out_cout, out_ovf, es, ec, eo); end
    consume();
  endtask

  task automatic test_random();
    logic [15:0] a, b, es;
    logic cin, ec, eo;
    int lat;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef SUB_EN
      sub_sel = 1'($urandom);
`else
      sub_sel = 1'b0;
`endif
      model(a, b, cin, sub_sel, es, ec, eo);
      do_op(a, b, cin, lat);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rnd%0d_latency got %0d exp 5", i, lat); end
      n_checks++; if ({out_sum, out_cout, out_ovf} !== {es, ec, eo}) begin n_fail++; $display("FAIL rnd%0d_result a=%h b=%h cin=%b sub=%b got %h/%b/%b exp %h/%b/%b", i, a, b, cin, sub_sel, out_sum, out_cout, out_ovf, es, ec, eo); end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      consume();
    end
    sub_sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, es;
    logic ec, eo;
    int prev = 0;
    int w;
    sub_sel = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      a = 16'($urandom); b = 16'($urandom);
      in_a = a; in_b = b; in_cin = 1'b0; in_valid = 1'b1;
      model(a, b, 1'b0, 1'b0, es, ec, eo);
      if (k > 0) begin
        n_checks++; if (cyc - prev !== 6) begin n_fail++; $display("FAIL b2b%0d_period got %0d exp 6", k, cyc - prev); end
      end
      prev = cyc;
      w = 0;
      @(posedge clk); #1;
      while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
      n_checks++; if ({out_sum, out_cout, out_ovf} !== {es, ec, eo}) begin n_fail++; $display("FAIL b2b%0d_result got %h/%b/%b exp %h/%b/%b", k, out_sum, out_cout, out_ovf, es, ec, eo); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

`ifdef SUB_EN
  task automatic test_sub();
    logic [15:0] ta [2] = '{16'h0005, 16'h8000};
    logic [15:0] tb [2] = '{16'h0007, 16'h0001};
    logic [15:0] es [2] = '{16'hFFFE, 16'h7FFF};
    logic        ec [2] = '{1'b0, 1'b1};
    logic        eo [2] = '{1'b0, 1'b1};
    int lat;
    sub_sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_op(ta[i], tb[i], 1'(i), lat);
      n_checks++; if ({out_sum, out_cout, out_ovf} !== {es[i], ec[i], eo[i]}) begin n_fail++; $display("FAIL sub%0d_result got %h/%b/%b exp %h/%b/%b", i, out_sum, out_cout, out_ovf, es[i], ec[i], eo[i]); end
      consume();
    end
    sub_sel = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_directed();
    test_hold();
    test_reset_mid();
`ifdef SUB_EN
    test_sub();
`endif
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
